// File: rtl/output_display.sv
// ----------------------------------------------------------------------------
// output_display
//
// Output register and four-digit seven-segment driver. A load strobe latches
// the bus value, which is then converted from binary to BCD by a sequential
// double-dabble engine (one shift-and-add-3 step per cycle, 8 cycles). The
// finished BCD digits and the sign are copied to the display registers in a
// single update, so the display never shows a partially converted value. A
// free-running refresh counter time-multiplexes the four digits.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   load         output-register load strobe (controller's oi signal)
//   data_in      8-bit system bus value
//   signed_mode  1: interpret data_in as two's complement
//   seg          active-high segments, seg[6:0] = g,f,e,d,c,b,a
//   digit_en     one-hot digit select (bit 0 ones .. bit 3 sign)
//   value        last latched bus value
//   busy         high while a conversion is in progress
// ----------------------------------------------------------------------------
module output_display #(
    parameter int unsigned REFRESH_BITS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data_in,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic [3:0] digit_en,
    output logic [7:0] value,
    output logic       busy
);

    localparam logic IDLE = 1'b0;
    localparam logic CONV = 1'b1;

    localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = 1;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                    state_q, state_d;
    logic [2:0]              step_q, step_d;
    logic [7:0]              bin_q, bin_d;
    logic [11:0]             bcd_q, bcd_d;
    logic                    conv_neg_q, conv_neg_d;
    logic [7:0]              value_q, value_d;
    logic [11:0]             disp_bcd_q, disp_bcd_d;
    logic                    disp_neg_q, disp_neg_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;

    // ------------------------------------------------------------------------
    // Magnitude / sign of the incoming bus value
    // ------------------------------------------------------------------------
    logic       neg_in;
    logic [7:0] mag_in;

    // An 8-bit negation is enough: the largest magnitude is 128 (from 0x80),
    // which still fits in 8 unsigned bits.
    assign neg_in = signed_mode & data_in[7];
    assign mag_in = neg_in ? (~data_in + 8'd1) : data_in;

    // ------------------------------------------------------------------------
    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift the
    // {bcd, bin} pair left by one.
    // ------------------------------------------------------------------------
    logic [11:0] bcd_adj;
    logic [11:0] bcd_shift;
    logic [7:0]  bin_shift;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = (bcd_adj << 1) | {11'b0, bin_q[7]};
        bin_shift = {bin_q[6:0], 1'b0};
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        conv_neg_d = conv_neg_q;
        value_d    = value_q;
        disp_bcd_d = disp_bcd_q;
        disp_neg_d = disp_neg_q;
        refresh_d  = refresh_q + REFRESH_ONE;

        if (load) begin
            // A new load always (re)starts the conversion, even on the edge
            // that would have finished the previous one.
            value_d    = data_in;
            conv_neg_d = neg_in;
            bin_d      = mag_in;
            bcd_d      = '0;
            step_d     = '0;
            state_d    = CONV;
        end else if (state_q == CONV) begin
            bin_d  = bin_shift;
            bcd_d  = bcd_shift;
            step_d = step_q + 3'd1;
            if (step_q == 3'd7) begin
                state_d    = IDLE;
                disp_bcd_d = bcd_shift;
                disp_neg_d = conv_neg_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            conv_neg_q <= 1'b0;
            value_q    <= '0;
            disp_bcd_q <= '0;
            disp_neg_q <= 1'b0;
            refresh_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            conv_neg_q <= conv_neg_d;
            value_q    <= value_d;
            disp_bcd_q <= disp_bcd_d;
            disp_neg_q <= disp_neg_d;
            refresh_q  <= refresh_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    logic [1:0] sel;
    logic [3:0] dig_hund, dig_tens, dig_ones;

    assign sel      = refresh_q[REFRESH_BITS-1 -: 2];
    assign dig_hund = disp_bcd_q[11:8];
    assign dig_tens = disp_bcd_q[7:4];
    assign dig_ones = disp_bcd_q[3:0];

    // seg and digit_en both derive from the same registered sel, so they
    // always change together.
    always_comb begin
        seg = SEG_BLANK;
        unique case (sel)
            2'd0: seg = seg_code(dig_ones);
            2'd1: seg = (dig_hund == 4'd0 && dig_tens == 4'd0) ? SEG_BLANK
                                                                 : seg_code(dig_tens);
            2'd2: seg = (dig_hund == 4'd0) ? SEG_BLANK : seg_code(dig_hund);
            2'd3: seg = disp_neg_q ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    assign digit_en = 4'b0001 << sel;
    assign value    = value_q;
    assign busy     = (state_q == CONV);

endmodule

// File: tb/tb_output_display.sv
module tb_output_display;

    localparam int unsigned RB = 4;

    logic       clk = 1'b0;
    logic       rst, load, signed_mode;
    logic [7:0] data_in;
    logic [6:0] seg;
    logic [3:0] digit_en;
    logic [7:0] value;
    logic       busy;

    always #5 clk = ~clk;

    output_display #(.REFRESH_BITS(RB)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .data_in     (data_in),
        .signed_mode (signed_mode),
        .seg         (seg),
        .digit_en    (digit_en),
        .value       (value),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: decimal magnitudes and a countdown, no BCD machinery.
    int m_cnt;       // refresh counter value
    int m_left;      // conversion cycles still to go (0 = idle)
    int m_value;
    int m_pmag;      // magnitude being converted
    bit m_pneg;
    int m_dmag;      // magnitude on display
    bit m_dneg;

    logic [6:0] codes [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int sel);
        case (sel)
            0:       return codes[m_dmag % 10];
            1:       return (m_dmag < 10) ? 7'h00 : codes[(m_dmag / 10) % 10];
            2:       return (m_dmag < 100) ? 7'h00 : codes[m_dmag / 100];
            default: return m_dneg ? 7'h40 : 7'h00;
        endcase
    endfunction

    // Apply inputs for one edge, advance the model, then check all outputs.
    task automatic cycle(input bit r, input bit l, input logic [7:0] d, input bit sm);
        int sel;
        rst = r; load = l; data_in = d; signed_mode = sm;
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_left = 0; m_value = 0; m_dmag = 0; m_dneg = 0;
        end else begin
            m_cnt = (m_cnt + 1) % (1 << RB);
            if (l) begin
                m_value = int'(d);
                m_pneg  = sm && d[7];
                m_pmag  = m_pneg ? 256 - int'(d) : int'(d);
                m_left  = 8;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_dmag = m_pmag;
                    m_dneg = m_pneg;
                end
            end
        end
        #1;
        sel = m_cnt / (1 << (RB - 2));
        check_eq("busy", 32'(busy), 32'(m_left > 0));
        check_eq("value", 32'(value), 32'(m_value));
        check_eq("digit_en", 32'(digit_en), 32'(1 << sel));
        check_eq("seg", 32'(seg), 32'(exp_seg(sel)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Wait out a conversion, then sweep a full refresh period.
    task automatic settle();
        idle(8 + (1 << RB));
    endtask

    initial begin
        m_cnt = 0; m_left = 0; m_value = 0; m_pmag = 0; m_pneg = 0;
        m_dmag = 0; m_dneg = 0;
        rst = 1'b1; load = 1'b0; data_in = 8'h00; signed_mode = 1'b0;

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("reset_digit_en", 32'(digit_en), 32'h1);
        check_eq("reset_seg", 32'(seg), 32'h3F);
        idle(2 * (1 << RB));                       // refresh sequence

        cycle(1'b0, 1'b1, 8'hFF, 1'b0); settle();  // 255
        check_eq("dir_255_value", 32'(value), 32'hFF);
        cycle(1'b0, 1'b1, 8'hFF, 1'b1); settle();  // -1
        cycle(1'b0, 1'b1, 8'h80, 1'b1); settle();  // -128
        cycle(1'b0, 1'b1, 8'h0A, 1'b0); settle();  // 10

        cycle(1'b0, 1'b1, 8'h05, 1'b0); idle(2);   // restart: 5 then 42
        cycle(1'b0, 1'b1, 8'h2A, 1'b0); settle();

        cycle(1'b0, 1'b1, 8'h63, 1'b0); idle(3);   // reset in 4th CONV cycle
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check_eq("abort_busy", 32'(busy), 32'h0);
        idle(1 << RB);

        cycle(1'b0, 1'b1, 8'h11, 1'b0); idle(7);   // load on the final step
        cycle(1'b0, 1'b1, 8'hC8, 1'b0); settle();

        cycle(1'b0, 1'b1, 8'h33, 1'b0);            // rst overrides load
        cycle(1'b1, 1'b1, 8'h77, 1'b1);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0),
                  8'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_display.md
OUTPUT_DISPLAY -- requirements
Module: output_display

Interface
REQ-001 Parameter REFRESH_BITS, default 10: width of the free-running digit-multiplex counter; legal range is 4 or more.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 Port load, input, 1 bit: output-register load strobe, driven by the controller's oi signal.
REQ-005 Port data_in, input, 8 bits: value on the system bus.
REQ-006 Port signed_mode, input, 1 bit: 1 means interpret data_in as two's complement.
REQ-007 Port seg, output, 7 bits: active-high segments; seg[6:0] = g,f,e,d,c,b,a.
REQ-008 Port digit_en, output, 4 bits: one-hot active-high digit select; bit 0 is the ones digit, bit 3 is the sign digit.
REQ-009 Port value, output, 8 bits: last latched bus value.
REQ-010 Port busy, output, 1 bit: high while a binary-to-BCD conversion is in progress.

Function
REQ-011 A rising edge with load=1 shall capture data_in into value and sample signed_mode.
- The FSM enters CONV with step count 0.
REQ-012 Magnitude rule: if sampled signed_mode=1 and data_in[7]=1, magnitude = (~data_in + 1) as a 9-bit quantity, and the sign flag is set.
- This gives 0x80 -> 128.
- Otherwise magnitude = data_in and the sign flag is clear.
REQ-013 FSM states shall be IDLE and CONV; busy = (state == CONV).
REQ-014 In CONV, each edge shall perform one shift-and-add-3 (double-dabble) step on a 12-bit BCD accumulator.
- Step count 0..7.
- On the step with count=7 the FSM returns to IDLE.
- The displayed digit registers update on that same edge.
- busy is therefore high for exactly 8 cycles after the load edge.
REQ-015 The displayed digit registers shall hold their previous contents throughout CONV.
- No partial results are ever shown.
REQ-016 load=1 while in CONV shall restart the conversion with the new data_in: latest wins, step count reset to 0.
REQ-017 load=1 on the same edge as the final step shall take priority.
- The pending result is discarded.
- The FSM stays in CONV for the new value.
REQ-018 Leading-zero blanking:
- Hundreds digit is blank if 0.
- Tens digit is blank if hundreds and tens are both 0.
- Ones digit is always shown.
REQ-019 The sign digit shall show minus (seg=0x40) when the sign flag is set, else blank (0x00).
REQ-020 Segment codes shall be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, blank=0x00.
REQ-021 The refresh counter (REFRESH_BITS wide) shall increment every cycle and wrap to 0.
- Its top two bits sel select the digit.
- digit_en = 1 << sel.
- seg shows the code for digit sel in the same cycle (registered or combinational from registered state; no cycle skew between seg and digit_en).
REQ-022 Multiplexing shall run continuously, independent of busy and load.

Reset
REQ-023 With rst=1 at an edge, all of the following shall hold, regardless of the FSM state:
- state = IDLE, busy = 0, value = 0x00, sign flag clear.
- Displayed digits = blank, blank, blank, "0".
- Refresh counter = 0, so digit_en = 0001 and seg = 0x3F.
REQ-024 rst shall override load on the same edge.
REQ-025 A reset during CONV shall abort the conversion with no display update.

Verification
REQ-026 Load 0xFF with signed_mode=0 -> busy high 8 cycles, then digits = blank,"2","5","5" and value = 0xFF.
REQ-027 Load 0xFF with signed_mode=1 -> sign digit 0x40, then blank, blank, "1" (0x06); load 0x80 signed -> "-128".
REQ-028 Load 0x05 (unsigned), then load 0x2A three cycles later -> busy stays high 8 cycles after the second load; the display never shows 5; final display is "42".
REQ-029 Assert rst in the 4th CONV cycle of a load of 0x63 -> next cycle busy=0, value=0x00, display shows "0".
REQ-030 With REFRESH_BITS=4 after reset -> digit_en holds each one-hot code for 4 cycles, sequence 0001, 0010, 0100, 1000, repeating.
REQ-031 Load 0x0A unsigned -> hundreds blank, tens "1" (0x06), ones "0" (0x3F).
